vliw_bundle_packer: RTL and testbench

- Upstream producer for the 4-slot VLIW core. Accepts a serial stream of 32-bit scalar instructions and packs them, in program order, into 128-bit bundles the core issues in one cycle.
- A bundle closes when it is full, on an intra-bundle hazard (RAW/WAW), on an explicit last marker, or on an idle timeout.
- Sits between the instruction source/scheduler and the core's 128-bit instruction input.

---
 rtl/vliw_pkg.sv | 38 +++
 rtl/vliw_hazard_check.sv | 22 ++
 rtl/vliw_bundle_packer.sv | 137 +++++++++++++
 tb/tb_vliw_bundle_packer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW bundle packer: opcodes, instruction layout
// and the per-opcode register read sets.
package vliw_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b100;

    localparam int OP_LSB    = 0;
    localparam int DEST_LSB  = 3;
    localparam int SRC1_LSB  = 6;
    localparam int SRC2_LSB  = 9;
    localparam int IMM_LSB   = 12;
    localparam int VALID_BIT = 31;

    // First member is the MSB, so this matches the [31:0] scalar layout.
    typedef struct packed {
        logic        valid;
        logic [18:0] imm;
        logic [2:0]  src2;
        logic [2:0]  src1;
        logic [2:0]  dest;
        logic [2:0]  op;
    } instr_t;

    localparam instr_t NOP = '0;

    function automatic logic reads_src1(input logic [2:0] op);
        return op != OP_MOV;
    endfunction

    // Unknown opcodes read both sources so they are never packed unsafely.
    function automatic logic reads_src2(input logic [2:0] op);
        return !(op == OP_MOV || op == OP_ADDI);
    endfunction

endpackage

// File: rtl/vliw_hazard_check.sv
// Flags a RAW or WAW hazard between an incoming instruction and the
// destinations already written by the bundle being filled.
module vliw_hazard_check
    import vliw_pkg::*;
(
    input  logic [31:0] in_instr,
    input  logic [7:0]  wmask,
    output logic        conflict
);

    instr_t instr;
    logic   unused_bits;

    assign instr       = instr_t'(in_instr);
    assign unused_bits = ^{instr.valid, instr.imm};

    // WAR is deliberately absent: all slots read the register file together.
    assign conflict = (reads_src1(instr.op) && wmask[instr.src1])
                   || (reads_src2(instr.op) && wmask[instr.src2])
                   || wmask[instr.dest];

endmodule

// File: rtl/vliw_bundle_packer.sv
// Packs a serial stream of 32-bit scalar instructions, in program order, into
// 128-bit 4-slot bundles closed on full, hazard, last marker or idle timeout.
module vliw_bundle_packer
    import vliw_pkg::*;
#(
    parameter int SLOTS        = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic         in_last,
    output logic         bundle_valid,
    input  logic         bundle_ready,
    output logic [127:0] bundle,
    output logic [2:0]   bundle_count
);

    localparam int         IW        = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

    logic [3:0][31:0] slots_q, slots_d, emit_slots;
    logic [2:0]       cnt_q, cnt_d, emit_cnt;
    logic [7:0]       wmask_q, wmask_d, dest_bit;
    logic [IW-1:0]    idle_q, idle_d;
    logic             close_pending_q, close_pending_d;
    logic             out_can_load, accept, emit, hazard, conflict;

    assign out_can_load = !bundle_valid || bundle_ready;
    assign in_ready     = out_can_load && !close_pending_q;
    assign accept       = in_valid && in_ready;
    assign dest_bit     = 8'b1 << in_instr[DEST_LSB +: 3];

    vliw_hazard_check u_hazard (
        .in_instr (in_instr),
        .wmask    (wmask_q),
        .conflict (hazard)
    );

    assign conflict = in_instr[VALID_BIT] && (cnt_q != 3'd0) && hazard;

    // NOTE: every variable below gets a default first so no latch is inferred.
    always_comb begin
        slots_d         = slots_q;
        cnt_d           = cnt_q;
        wmask_d         = wmask_q;
        idle_d          = idle_q;
        close_pending_d = close_pending_q;
        emit            = 1'b0;
        emit_slots      = slots_q;
        emit_cnt        = cnt_q;

        if (accept) begin
            idle_d = '0;
            if (!in_instr[VALID_BIT]) begin
                if (in_last && cnt_q != 3'd0) begin
                    emit    = 1'b1;
                    slots_d = '0;
                    cnt_d   = 3'd0;
                    wmask_d = '0;
                end
            end else if (conflict) begin
                emit            = 1'b1;
                slots_d         = '0;
                slots_d[0]      = in_instr;
                cnt_d           = 3'd1;
                wmask_d         = dest_bit;
                close_pending_d = in_last;
            end else begin
                emit_slots[cnt_q[1:0]] = in_instr;
                emit_cnt               = cnt_q + 3'd1;
                if (cnt_q == LAST_SLOT || in_last) begin
                    emit    = 1'b1;
                    slots_d = '0;
                    cnt_d   = 3'd0;
                    wmask_d = '0;
                end else begin
                    slots_d = emit_slots;
                    cnt_d   = emit_cnt;
                    wmask_d = wmask_q | dest_bit;
                end
            end
        end else if (close_pending_q) begin
            if (out_can_load) begin
                emit            = (cnt_q != 3'd0);
                slots_d         = '0;
                cnt_d           = 3'd0;
                wmask_d         = '0;
                close_pending_d = 1'b0;
                idle_d          = '0;
            end
        end else if (cnt_q == 3'd0) begin
            idle_d = '0;
        end else if (IDLE_TIMEOUT != 0) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IW'(IDLE_TIMEOUT)) begin
                close_pending_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; the slot buffer
    // is reset as well so a reset mid-fill cannot leak old instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q         <= '0;
            cnt_q           <= 3'd0;
            wmask_q         <= '0;
            idle_q          <= '0;
            close_pending_q <= 1'b0;
        end else begin
            slots_q         <= slots_d;
            cnt_q           <= cnt_d;
            wmask_q         <= wmask_d;
            idle_q          <= idle_d;
            close_pending_q <= close_pending_d;
        end
    end

    // Emits only happen while out_can_load, so a held bundle is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_valid <= 1'b0;
            bundle       <= '0;
            bundle_count <= 3'd0;
        end else if (emit) begin
            bundle_valid <= 1'b1;
            bundle       <= emit_slots;
            bundle_count <= emit_cnt;
        end else if (bundle_ready) begin
            bundle_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Self-checking bench for vliw_bundle_packer: directed scenarios plus a
// randomized run against a queue-based reference model of the packing rules.
module tb_vliw_bundle_packer;

    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_instr = '0;
    logic         in_last = 1'b0;
    logic         bundle_valid;
    logic         bundle_ready = 1'b1;
    logic [127:0] bundle;
    logic [2:0]   bundle_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the open bundle as a queue of words, plus output register.
    logic [31:0]  mq[$];
    int           m_idle = 0;
    bit           m_pend = 1'b0;
    bit           m_bv = 1'b0;
    logic [127:0] m_bundle = '0;
    int           m_bcnt = 0;
    int           n_emit = 0;

    vliw_bundle_packer #(.SLOTS(4), .IDLE_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_last      (in_last),
        .bundle_valid (bundle_valid),
        .bundle_ready (bundle_ready),
        .bundle       (bundle),
        .bundle_count (bundle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] op, input int d, input int s1,
                                       input int s2, input int imm);
        return {1'b1, 19'(imm), 3'(s2), 3'(s1), 3'(d), op};
    endfunction

    function automatic logic [31:0] mov(input int d, input int imm);
        return mk(3'b100, d, 0, 0, imm);
    endfunction

    function automatic bit reads_a(input logic [2:0] op);
        return op != 3'b100;
    endfunction

    function automatic bit reads_b(input logic [2:0] op);
        return op != 3'b100 && op != 3'b010;
    endfunction

    // RAW or WAW against any instruction already in the open bundle.
    function automatic bit m_conflict(input logic [31:0] w);
        foreach (mq[i]) begin
            if (w[5:3] == mq[i][5:3]) return 1'b1;
            if (reads_a(w[2:0]) && w[8:6] == mq[i][5:3]) return 1'b1;
            if (reads_b(w[2:0]) && w[11:9] == mq[i][5:3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_close(input logic [31:0] e[$]);
        logic [127:0] r;
        r = '0;
        foreach (e[i]) r[i*32 +: 32] = e[i];
        m_bv     = 1'b1;
        m_bundle = r;
        m_bcnt   = e.size();
        n_emit++;
    endtask

    task automatic model_update(input bit v, input logic [31:0] ins, input bit last, input bit br);
        bit can, acc, emitted;
        logic [31:0] e[$];
        can     = !m_bv || br;
        acc     = v && can && !m_pend;
        emitted = 1'b0;
        if (acc) begin
            m_idle = 0;
            if (!ins[31]) begin
                if (last && mq.size() > 0) begin
                    e = mq; mq = {}; emitted = 1'b1;
                end
            end else if (mq.size() > 0 && m_conflict(ins)) begin
                e = mq; mq = {ins}; emitted = 1'b1; m_pend = last;
            end else begin
                mq.push_back(ins);
                if (mq.size() == 4 || last) begin
                    e = mq; mq = {}; emitted = 1'b1;
                end
            end
        end else if (m_pend) begin
            if (can) begin
                e = mq; mq = {}; emitted = (e.size() > 0); m_pend = 1'b0; m_idle = 0;
            end
        end else if (mq.size() == 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_pend = 1'b1;
        end
        if (emitted) m_close(e);
        else if (br) m_bv = 1'b0;
    endtask

    // One clock of stimulus; starts and ends 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit last, input bit br);
        bit exp_rdy;
        in_valid = v; in_instr = ins; in_last = last; bundle_ready = br;
        #1;
        exp_rdy = (!m_bv || br) && !m_pend;
        n_vec++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
        end
        model_update(v, ins, last, br);
        @(posedge clk); #1;
        n_vec++;
        if (bundle_valid !== m_bv) begin
            n_err++;
            $display("FAIL bundle_valid t=%0t got %b want %b", $time, bundle_valid, m_bv);
        end
        if (m_bv) begin
            n_vec++;
            if (bundle !== m_bundle || bundle_count !== 3'(m_bcnt)) begin
                n_err++;
                $display("FAIL bundle t=%0t got %h/%0d want %h/%0d",
                         $time, bundle, bundle_count, m_bundle, m_bcnt);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; bundle_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq = {}; m_idle = 0; m_pend = 1'b0; m_bv = 1'b0; m_bundle = '0; m_bcnt = 0;
        n_vec++;
        if (bundle_valid !== 1'b0 || bundle !== '0 || bundle_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b/%h/%0d want 0/0/0", bundle_valid, bundle, bundle_count);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_pack_four();
        step(1, mov(1, 5), 0, 1);
        step(1, mov(2, 7), 0, 1);
        step(1, mov(3, 1), 0, 1);
        n_vec++;
        if (bundle_valid !== 1'b0) begin
            n_err++;
            $display("FAIL four_early got valid %b want 0", bundle_valid);
        end
        step(1, mov(4, 2), 0, 1);
        n_vec++;
        if (bundle_valid !== 1'b1 || bundle_count !== 3'd4 || bundle[31:0] !== 32'h8000500C
            || bundle !== {mov(4, 2), mov(3, 1), mov(2, 7), mov(1, 5)}) begin
            n_err++;
            $display("FAIL four_pack got %b/%0d/%h want 1/4/slot0 8000500C",
                     bundle_valid, bundle_count, bundle);
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_raw_timeout();
        logic [31:0] add_w;
        int waited;
        add_w = mk(3'b000, 2, 1, 1, 0);
        step(1, mov(1, 5), 0, 1);
        step(1, add_w, 0, 1);
        n_vec++;
        if (bundle_valid !== 1'b1 || bundle_count !== 3'd1 || bundle !== 128'h8000500C) begin
            n_err++;
            $display("FAIL raw_split got %b/%0d/%h want 1/1/8000500C", bundle_valid, bundle_count, bundle);
        end
        // Timer reaches 8 on the 8th idle edge, close_pending flushes on the next.
        waited = 0;
        for (int i = 1; i <= 20 && waited == 0; i++) begin
            step(0, '0, 0, 1);
            if (bundle_valid === 1'b1) waited = i;
        end
        n_vec++;
        if (waited != TIMEOUT + 1) begin
            n_err++;
            $display("FAIL raw_timeout got %0d idle cycles want %0d (0 = never)", waited, TIMEOUT + 1);
        end
        n_vec++;
        if (bundle !== {96'h0, add_w} || bundle_count !== 3'd1) begin
            n_err++;
            $display("FAIL raw_tail got %h/%0d want %h/1", bundle, bundle_count, {96'h0, add_w});
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_waw_war();
        int e0;
        e0 = n_emit;
        step(1, mk(3'b010, 3, 0, 0, 1), 0, 1);
        step(1, mov(3, 9), 1, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        n_vec++;
        if (n_emit - e0 != 2) begin
            n_err++;
            $display("FAIL waw_split got %0d bundles want 2", n_emit - e0);
        end
        step(1, mk(3'b000, 1, 2, 3, 0), 0, 1);
        step(1, mov(2, 4), 1, 1);
        n_vec++;
        if (bundle_valid !== 1'b1 || bundle_count !== 3'd2
            || bundle !== {64'h0, mov(2, 4), mk(3'b000, 1, 2, 3, 0)}) begin
            n_err++;
            $display("FAIL war_pack got %b/%0d/%h want 1/2", bundle_valid, bundle_count, bundle);
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        held = {mov(4, 4), mov(3, 3), mov(2, 2), mov(1, 1)};
        for (int i = 1; i <= 4; i++) step(1, mov(i, i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, mov(7, 3), 0, 0);
            n_vec++;
            if (in_ready !== 1'b0 || bundle !== held || bundle_count !== 3'd4) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d got rdy %b %h/%0d want rdy 0 %h/4",
                         i, in_ready, bundle, bundle_count, held);
            end
        end
        bundle_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got in_ready %b want 1", in_ready);
        end
        step(1, mov(7, 3), 1, 1);
        step(0, '0, 0, 1);
    endtask

    task automatic test_last_conflict();
        int e0;
        step(1, mov(5, 1), 0, 1);
        e0 = n_emit;
        step(1, mov(5, 2), 1, 1);
        n_vec++;
        if (bundle_valid !== 1'b1 || bundle !== {96'h0, mov(5, 1)}) begin
            n_err++;
            $display("FAIL lastc_first got %b/%h want 1/%h", bundle_valid, bundle, mov(5, 1));
        end
        step(0, '0, 0, 1);
        n_vec++;
        if (bundle_valid !== 1'b1 || bundle_count !== 3'd1 || bundle !== {96'h0, mov(5, 2)}
            || n_emit - e0 != 2) begin
            n_err++;
            $display("FAIL lastc_second got %b/%0d/%h want 1/1/%h", bundle_valid, bundle_count, bundle, mov(5, 2));
        end
        step(1, 32'h0000_600C, 0, 1);
        step(1, mov(6, 3), 1, 1);
        n_vec++;
        if (bundle_count !== 3'd1 || bundle !== {96'h0, mov(6, 3)}) begin
            n_err++;
            $display("FAIL invalid_drop got %0d/%h want 1/%h", bundle_count, bundle, mov(6, 3));
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_reset_midfill();
        for (int i = 1; i <= 3; i++) step(1, mov(i, i + 10), 0, 1);
        test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 1);
            n_vec++;
            if (bundle_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midfill_flush got valid %b want 0", bundle_valid);
            end
        end
        for (int i = 4; i <= 7; i++) step(1, mov(i, i), 0, 1);
        n_vec++;
        if (bundle_count !== 3'd4 || bundle !== {mov(7, 7), mov(6, 6), mov(5, 5), mov(4, 4)}) begin
            n_err++;
            $display("FAIL midfill_fresh got %0d/%h want 4", bundle_count, bundle);
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            w[31] = ($urandom_range(0, 9) != 0);
            step($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 2 * TIMEOUT; i++) step(0, '0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_pack_four();
        test_raw_timeout();
        test_waw_war();
        test_backpressure();
        test_last_conflict();
        test_reset_midfill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
